exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000020, exception handler entry address.
REQ-002 SHALL have parameter BLANK_CYCLES, default 3, cycles MEM inputs are ignored after a flush; legal range 1..15.
REQ-003 SHALL have clk  in  1  clock; reset rst, synchronous, active-high.
REQ-004 SHALL have int_i  in  6  external hardware interrupt lines, asynchronous.
REQ-005 SHALL have int_sync_o  out  6  synchronised int_i, driven to the CP0 register block interrupt input.
REQ-006 SHALL have mem_valid_i  in  1  MEM stage holds a real instruction.
REQ-007 SHALL have mem_pc_i  in  32  MEM instruction PC.
REQ-008 SHALL have mem_exc_i  in  5  exception flags: [0] syscall, [1] invalid instr, [2] trap, [3] overflow, [4] eret.
REQ-009 SHALL have mem_in_ds_i  in  1  MEM instruction is in a branch delay slot.
REQ-010 SHALL have cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 Status/Cause/EPC.
REQ-011 SHALL have wb_cp0_we_i  in  1, wb_cp0_waddr_i  in  5, wb_cp0_data_i  in  32  CP0 write pending in WB.
REQ-012 SHALL have flush_o  out  1  pipeline flush pulse.
REQ-013 SHALL have new_pc_o  out  32  redirect PC, valid while flush_o=1.
REQ-014 SHALL have exc_we_o  out  1, exc_code_o  out  5, exc_epc_o  out  32, exc_bd_o  out  1, exc_eret_o  out  1  CP0 exception update port.
REQ-015 SHALL have busy_o  out  1  high in FLUSH and BLANK states.

Function
REQ-016 SHALL pass int_i through two clk flops to int_sync_o (2-cycle latency).
REQ-017 SHALL form effective Status = wb_cp0_data_i when wb_cp0_we_i=1 and waddr=12, else cp0_status_i.
REQ-018 SHALL form effective Cause = cp0_cause_i with bits 9:8, 23, 22 replaced by wb_cp0_data_i when wb_cp0_we_i=1 and waddr=13.
REQ-019 SHALL form effective EPC = wb_cp0_data_i when wb_cp0_we_i=1 and waddr=14, else cp0_epc_i.
REQ-020 SHALL treat interrupt pending = Status[0]=1 and Status[1]=0 and (Cause[15:8] & Status[15:8]) != 0, effective values.
REQ-021 SHALL evaluate events only in IDLE with mem_valid_i=1; otherwise none taken and nothing lost (interrupt stays pending).
REQ-022 SHALL prioritise: interrupt (code 0) > syscall (8) > invalid (10) > trap (13) > overflow (12) > eret (14); one event per evaluation.
REQ-023 SHALL implement states IDLE, FLUSH, BLANK; IDLE->FLUSH on taken event; FLUSH->BLANK after 1 cycle; BLANK->IDLE after BLANK_CYCLES cycles via down-counter.
REQ-024 SHALL, in the cycle after the event is sampled, register flush_o=1 and exc_we_o=1 for exactly one cycle (FLUSH state).
REQ-025 SHALL set new_pc_o = EXC_VECTOR for codes 0/8/10/12/13 and effective EPC sampled at detection for eret.
REQ-026 SHALL set exc_epc_o = mem_pc_i - 4 (mod 2^32) and exc_bd_o=1 when mem_in_ds_i=1, else mem_pc_i and 0.
REQ-027 SHALL set exc_eret_o=1 only for eret; exc_code_o=14 then and exc_epc_o/exc_bd_o driven 0.
REQ-028 SHALL ignore mem_valid_i, mem_exc_i and interrupts throughout FLUSH and BLANK.
REQ-029 SHALL drive flush_o, exc_we_o, exc_eret_o to 0 and hold new_pc_o/exc_* at last values outside FLUSH.

Reset
REQ-030 SHALL on rst set state IDLE, counter 0, int_sync_o 0, flush_o 0, new_pc_o 0, exc_we_o 0, exc_code_o 0, exc_epc_o 0, exc_bd_o 0, exc_eret_o 0, busy_o 0.
REQ-031 SHALL abort FLUSH/BLANK immediately on rst in any cycle; no partial pulse after rst deasserts.

Verification
REQ-032 Syscall: mem_valid=1, mem_exc=5'b00001, pc=0x100, ds=0 -> next cycle flush=1, new_pc=0x20, code=8, epc=0x100, bd=0; busy for 1+3 cycles.
REQ-033 Interrupt vs overflow: Status=0x0000_0401, int_i[0]=1 for 3 cycles, then mem_exc=overflow -> code=0 taken, overflow dropped.
REQ-034 Forwarding: cp0_epc=0x40, WB writes reg14=0x80 same cycle as eret -> new_pc=0x80, exc_eret=1, code=14.
REQ-035 Delay slot wrap: pc=0x0, ds=1, trap -> epc=0xFFFFFFFC, bd=1, code=13.
REQ-036 Blanking: invalid-instr flag held during FLUSH/BLANK -> single flush; held after return to IDLE -> second flush.
REQ-037 Reset mid-BLANK: rst one cycle -> busy=0, all outputs 0, next event handled normally.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Bus bundle between the pipeline/CP0 side and the exception controller.
// The slave modport is the controller's view; master is the driver's view.
interface exc_ctrl_if;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic [4:0]  mem_exc_i;
   logic        mem_in_ds_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        exc_we_o;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_epc_o;
   logic        exc_bd_o;
   logic        exc_eret_o;
   logic        busy_o;

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_exc_i, mem_in_ds_i,
      input  cp0_status_i, cp0_cause_i, cp0_epc_i,
      input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o, exc_eret_o, busy_o
   );

   modport master (
      output mem_valid_i, mem_pc_i, mem_exc_i, mem_in_ds_i,
      output cp0_status_i, cp0_cause_i, cp0_epc_i,
      output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o, exc_eret_o, busy_o
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: picks one event from the MEM stage, issues a
// one-cycle flush + CP0 update, then blanks MEM inputs while the pipe refills.
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int unsigned BLANK_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] int_i,
   output logic [5:0] int_sync_o,
   exc_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StFlush, StBlank} state_e;

   localparam logic [3:0] BlankLoad = 4'(BLANK_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  int_meta_q, int_sync_q;
   logic        flush_q, flush_d;
   logic        we_q, we_d;
   logic        eret_q, eret_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [31:0] epc_q, epc_d;
   logic        bd_q, bd_d;

   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pend;
   logic        evt_any;
   logic        evt_eret;
   logic [4:0]  evt_code;

   // Two-flop synchroniser for the asynchronous interrupt lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_meta_q <= '0;
         int_sync_q <= '0;
      end else begin
         int_meta_q <= int_i;
         int_sync_q <= int_meta_q;
      end
   end

   // Forward a CP0 write still sitting in WB so decisions see the newest value.
   always_comb begin
      status_eff = bus.cp0_status_i;
      cause_eff  = bus.cp0_cause_i;
      epc_eff    = bus.cp0_epc_i;
      if (bus.wb_cp0_we_i) begin
         unique case (bus.wb_cp0_waddr_i)
            5'd12: status_eff = bus.wb_cp0_data_i;
            5'd13: begin
               // Only the software-writable Cause fields are replaced.
               cause_eff[9:8]   = bus.wb_cp0_data_i[9:8];
               cause_eff[23:22] = bus.wb_cp0_data_i[23:22];
            end
            5'd14: epc_eff = bus.wb_cp0_data_i;
            default: ;
         endcase
      end
      int_pend = status_eff[0] && !status_eff[1] &&
                 ((cause_eff[15:8] & status_eff[15:8]) != 8'h00);
   end

   // Fixed-priority event select; at most one event per evaluation.
   always_comb begin
      evt_any  = 1'b1;
      evt_eret = 1'b0;
      evt_code = 5'd0;
      if (int_pend)                  evt_code = 5'd0;
      else if (bus.mem_exc_i[0])     evt_code = 5'd8;
      else if (bus.mem_exc_i[1])     evt_code = 5'd10;
      else if (bus.mem_exc_i[2])     evt_code = 5'd13;
      else if (bus.mem_exc_i[3])     evt_code = 5'd12;
      else if (bus.mem_exc_i[4]) begin
         evt_code = 5'd14;
         evt_eret = 1'b1;
      end else                       evt_any = 1'b0;
   end

   // Next-state and registered-output logic for the IDLE/FLUSH/BLANK sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flush_d  = 1'b0;
      we_d     = 1'b0;
      eret_d   = 1'b0;
      code_d   = code_q;
      new_pc_d = new_pc_q;
      epc_d    = epc_q;
      bd_d     = bd_q;
      unique case (state_q)
         StIdle: begin
            if (bus.mem_valid_i && evt_any) begin
               state_d = StFlush;
               flush_d = 1'b1;
               we_d    = 1'b1;
               eret_d  = evt_eret;
               code_d  = evt_code;
               if (evt_eret) begin
                  new_pc_d = epc_eff;
                  epc_d    = 32'h0;
                  bd_d     = 1'b0;
               end else begin
                  new_pc_d = EXC_VECTOR;
                  epc_d    = bus.mem_in_ds_i ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
                  bd_d     = bus.mem_in_ds_i;
               end
            end
         end
         StFlush: begin
            state_d = StBlank;
            cnt_d   = BlankLoad;
         end
         StBlank: begin
            if (cnt_q == 4'd0) state_d = StIdle;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any flush/blank in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         flush_q  <= 1'b0;
         we_q     <= 1'b0;
         eret_q   <= 1'b0;
         code_q   <= 5'd0;
         new_pc_q <= 32'h0;
         epc_q    <= 32'h0;
         bd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         we_q     <= we_d;
         eret_q   <= eret_d;
         code_q   <= code_d;
         new_pc_q <= new_pc_d;
         epc_q    <= epc_d;
         bd_q     <= bd_d;
      end
   end

   assign int_sync_o     = int_sync_q;
   assign bus.flush_o    = flush_q;
   assign bus.exc_we_o   = we_q;
   assign bus.exc_eret_o = eret_q;
   assign bus.exc_code_o = code_q;
   assign bus.new_pc_o   = new_pc_q;
   assign bus.exc_epc_o  = epc_q;
   assign bus.exc_bd_o   = bd_q;
   assign bus.busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios then random traffic, all checked
// against a cycle-count reference model of the exception rules.
module tb_exc_ctrl;
   localparam logic [31:0] Vec   = 32'h0000_0020;
   localparam int          Blank = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] int_i;
   logic [5:0] int_sync;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   exc_ctrl_if bus ();

   exc_ctrl #(
      .EXC_VECTOR   (Vec),
      .BLANK_CYCLES (Blank)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .int_i      (int_i),
      .int_sync_o (int_sync),
      .bus        (bus)
   );

   // Reference model: remaining busy cycles plus expected output values.
   int          m_left = 0;
   logic        m_flush, m_we, m_eret, m_bd;
   logic [4:0]  m_code;
   logic [31:0] m_newpc, m_epc;
   logic [5:0]  sq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      logic [31:0] st, ca, ep;
      logic        ip;
      int          code;
      if (rst) begin
         m_left = 0;  m_flush = 0; m_we = 0; m_eret = 0; m_bd = 0;
         m_code = 0;  m_newpc = 0; m_epc = 0;
      end else if (m_left > 0) begin
         m_left--;
         m_flush = 0; m_we = 0; m_eret = 0;
      end else begin
         m_flush = 0; m_we = 0; m_eret = 0;
         st = bus.cp0_status_i;
         ca = bus.cp0_cause_i;
         ep = bus.cp0_epc_i;
         if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 12) st = bus.wb_cp0_data_i;
         if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 13)
            ca = (ca & ~32'h00C0_0300) | (bus.wb_cp0_data_i & 32'h00C0_0300);
         if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 14) ep = bus.wb_cp0_data_i;
         ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 0);
         code = -1;
         if (bus.mem_valid_i) begin
            if (ip)                     code = 0;
            else if (bus.mem_exc_i[0])  code = 8;
            else if (bus.mem_exc_i[1])  code = 10;
            else if (bus.mem_exc_i[2])  code = 13;
            else if (bus.mem_exc_i[3])  code = 12;
            else if (bus.mem_exc_i[4])  code = 14;
         end
         if (code >= 0) begin
            m_left  = 1 + Blank;
            m_flush = 1;
            m_we    = 1;
            m_code  = 5'(code);
            if (code == 14) begin
               m_eret = 1; m_newpc = ep; m_epc = 0; m_bd = 0;
            end else begin
               m_newpc = Vec;
               m_epc   = bus.mem_in_ds_i ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
               m_bd    = bus.mem_in_ds_i;
            end
         end
      end
      @(posedge clk);
      if (rst) begin
         sq = {6'h0, 6'h0};
      end else begin
         sq.push_back(int_i);
         void'(sq.pop_front());
      end
      #1;
      cyc++;
      check("flush",    bus.flush_o,    m_flush);
      check("exc_we",   bus.exc_we_o,   m_we);
      check("exc_eret", bus.exc_eret_o, m_eret);
      check("exc_code", bus.exc_code_o, m_code);
      check("new_pc",   bus.new_pc_o,   m_newpc);
      check("exc_epc",  bus.exc_epc_o,  m_epc);
      check("exc_bd",   bus.exc_bd_o,   m_bd);
      check("busy",     bus.busy_o,     m_left != 0);
      check("int_sync", int_sync,       sq[0]);
   endtask

   task automatic clear_inputs();
      int_i              = 0;
      bus.mem_valid_i    = 0;
      bus.mem_pc_i       = 0;
      bus.mem_exc_i      = 0;
      bus.mem_in_ds_i    = 0;
      bus.cp0_status_i   = 0;
      bus.cp0_cause_i    = 0;
      bus.cp0_epc_i      = 0;
      bus.wb_cp0_we_i    = 0;
      bus.wb_cp0_waddr_i = 0;
      bus.wb_cp0_data_i  = 0;
   endtask

   task automatic idle(input int n);
      bus.mem_valid_i = 0;
      bus.mem_exc_i   = 0;
      bus.wb_cp0_we_i = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int flushes;
      sq = {6'h0, 6'h0};
      clear_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      check("reset_busy",  bus.busy_o,  1'b0);
      check("reset_flush", bus.flush_o, 1'b0);
      idle(1);

      // Syscall at 0x100, then busy for FLUSH + BLANK cycles.
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b00001; bus.mem_pc_i = 32'h100;
      step();
      check("sys_flush", bus.flush_o,    1'b1);
      check("sys_newpc", bus.new_pc_o,   32'h20);
      check("sys_code",  bus.exc_code_o, 5'd8);
      check("sys_epc",   bus.exc_epc_o,  32'h100);
      check("sys_bd",    bus.exc_bd_o,   1'b0);
      idle(3);
      check("sys_busy_tail", bus.busy_o, 1'b1);
      idle(1);
      check("sys_busy_done", bus.busy_o, 1'b0);

      // Trap in a delay slot at PC 0 wraps the EPC.
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b00100; bus.mem_pc_i = 32'h0;
      bus.mem_in_ds_i = 1;
      step();
      check("ds_epc",  bus.exc_epc_o,  32'hFFFF_FFFC);
      check("ds_bd",   bus.exc_bd_o,   1'b1);
      check("ds_code", bus.exc_code_o, 5'd13);
      bus.mem_in_ds_i = 0;
      idle(4);

      // ERET with EPC forwarded from a WB write.
      bus.cp0_epc_i = 32'h40; bus.wb_cp0_we_i = 1; bus.wb_cp0_waddr_i = 5'd14;
      bus.wb_cp0_data_i = 32'h80;
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b10000; bus.mem_pc_i = 32'h200;
      step();
      check("eret_newpc", bus.new_pc_o,   32'h80);
      check("eret_flag",  bus.exc_eret_o, 1'b1);
      check("eret_code",  bus.exc_code_o, 5'd14);
      check("eret_epc",   bus.exc_epc_o,  32'h0);
      idle(4);

      // Interrupt line 0 propagates; CP0 latches it as IP2 and it beats overflow.
      bus.cp0_status_i = 32'h0000_0401;
      int_i = 6'h01;
      for (int i = 0; i < 3; i++) step();
      check("int_sync0", int_sync, 6'h01);
      int_i = 0;
      bus.cp0_cause_i = 32'h0000_0400;
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b01000; bus.mem_pc_i = 32'h300;
      step();
      check("int_code", bus.exc_code_o, 5'd0);
      check("int_epc",  bus.exc_epc_o,  32'h300);
      bus.cp0_status_i = 0; bus.cp0_cause_i = 0;
      idle(4);

      // Invalid-instr held: one flush during blanking, another after return.
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b00010; bus.mem_pc_i = 32'h400;
      flushes = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.flush_o === 1'b1) flushes++;
      end
      check("blank_flushes", 32'(flushes), 32'd2);
      check("blank_code",    bus.exc_code_o, 5'd10);
      idle(4);

      // Reset mid-BLANK, then a normal event.
      bus.mem_valid_i = 1; bus.mem_exc_i = 5'b00001; bus.mem_pc_i = 32'h500;
      step();
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      check("rst_busy", bus.busy_o,   1'b0);
      check("rst_pc",   bus.new_pc_o, 32'h0);
      check("rst_epc",  bus.exc_epc_o, 32'h0);
      bus.mem_pc_i = 32'h600;
      step();
      check("post_rst_flush", bus.flush_o,    1'b1);
      check("post_rst_code",  bus.exc_code_o, 5'd8);
      idle(4);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         logic [31:0] st;
         logic [4:0]  ex;
         rst = ($urandom_range(0, 99) == 0);
         int_i = 6'($urandom);
         bus.mem_valid_i = $urandom_range(0, 1) == 1;
         bus.mem_pc_i    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         bus.mem_in_ds_i = $urandom_range(0, 2) == 0;
         ex = 0;
         for (int b = 0; b < 5; b++) ex[b] = ($urandom_range(0, 5) == 0);
         bus.mem_exc_i = ex;
         st = $urandom;
         st[0] = ($urandom_range(0, 3) != 0);
         st[1] = ($urandom_range(0, 3) == 0);
         bus.cp0_status_i   = st;
         bus.cp0_cause_i    = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
         bus.cp0_epc_i      = $urandom;
         bus.wb_cp0_we_i    = $urandom_range(0, 1) == 1;
         bus.wb_cp0_waddr_i = 5'($urandom_range(11, 14));
         bus.wb_cp0_data_i  = $urandom;
         step();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
